speaker_i2s_ctrl: RTL and testbench

Serializer between `note_gen` and the Pmod I2S DAC (CS4344). Takes the 16-bit `audio_left`/`audio_right` samples and emits the I2S bit stream: MCLK, LRCK, SCK and SDIN. All clocks are derived from the 100 MHz system clock by one free-running counter. Samples are latched once per frame so the left and right words always come from the same instant. A request strobe tells upstream logic when the samples are taken.

---
 rtl/speaker_i2s_ctrl_if.sv | 18 +
 rtl/speaker_i2s_ctrl.sv | 78 +++++++
 tb/tb_speaker_i2s_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/speaker_i2s_ctrl_if.sv
// speaker_i2s_ctrl_if
//   Sample bus between the upstream tone generator and the I2S serializer.
//   master : upstream source (drives samples and mute, sees sample_req)
//   slave  : serializer (reads samples and mute, drives sample_req)
//   audio_left/audio_right : DATA_W two's-complement samples
//   mute                   : zero both words at frame capture
//   sample_req             : one-cycle strobe, samples taken at the end of it
interface speaker_i2s_ctrl_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] audio_left;
   logic [DATA_W-1:0] audio_right;
   logic              mute;
   logic              sample_req;

   modport master (output audio_left, audio_right, mute, input sample_req);
   modport slave  (input audio_left, audio_right, mute, output sample_req);
endinterface

// File: rtl/speaker_i2s_ctrl.sv
// speaker_i2s_ctrl
//   I2S serializer for the CS4344 Pmod DAC. One free-running 11-bit counter
//   produces MCLK (clk/4), SCK (clk/32) and LRCK (clk/2048). Both channel
//   words are latched together once per frame and shifted out MSB first
//   with the I2S one-slot delay, zero-padded to 32 slots per channel.
// Ports:
//   clk        : 100 MHz system clock
//   rst        : asynchronous active-high reset
//   bus        : sample bus (slave side): audio_left, audio_right, mute in,
//                sample_req out
//   audio_mclk : master clock = cnt[1]
//   audio_sck  : bit clock    = cnt[4]
//   audio_lrck : word select  = cnt[10] (0 = left)
//   audio_sdin : serial data, changes on SCK falling edges
module speaker_i2s_ctrl #(
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   speaker_i2s_ctrl_if.slave   bus,
   output logic                audio_mclk,
   output logic                audio_sck,
   output logic                audio_lrck,
   output logic                audio_sdin
);
   localparam logic [4:0]  LP_DW   = 5'(DATA_W);
   localparam logic [10:0] LP_LAST = 11'h7FF;

   logic [10:0]       r_cnt;
   logic [DATA_W-1:0] r_shL;
   logic [DATA_W-1:0] r_shR;

   logic [10:0]       w_cnt_next;
   logic [4:0]        w_k;
   logic [4:0]        w_idx;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] w_shifted;
   logic              w_capture;
   logic              w_sdin_next;

   assign w_cnt_next = r_cnt + 11'd1;
   assign w_capture  = (r_cnt == LP_LAST);

   // Slot index of the cycle being entered. Data for slot k is bit
   // [DATA_W-k]; slot 0 is the I2S delay slot and slots past DATA_W pad.
   // The capture edge always enters slot 0, so reading the shadow words
   // before they update is safe.
   assign w_k         = w_cnt_next[9:5];
   assign w_idx       = LP_DW - w_k;
   assign w_word      = w_cnt_next[10] ? r_shR : r_shL;
   assign w_shifted   = w_word >> w_idx;
   assign w_sdin_next = (w_k != 5'd0) && (w_k <= LP_DW) && w_shifted[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt          <= '0;
         r_shL          <= '0;
         r_shR          <= '0;
         audio_mclk     <= 1'b0;
         audio_sck      <= 1'b0;
         audio_lrck     <= 1'b0;
         audio_sdin     <= 1'b0;
         bus.sample_req <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_capture) begin
            r_shL <= bus.mute ? '0 : bus.audio_left;
            r_shR <= bus.mute ? '0 : bus.audio_right;
         end
         // Registered from cnt_next so each pin equals its bit of cnt.
         audio_mclk     <= w_cnt_next[1];
         audio_sck      <= w_cnt_next[4];
         audio_lrck     <= w_cnt_next[10];
         audio_sdin     <= w_sdin_next;
         bus.sample_req <= (w_cnt_next == LP_LAST);
      end
   end
endmodule

// File: tb/tb_speaker_i2s_ctrl.sv
module tb_speaker_i2s_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   speaker_i2s_ctrl_if #(.DATA_W(16)) if16 ();
   speaker_i2s_ctrl_if #(.DATA_W(24)) if24 ();

   logic mclk16, sck16, lrck16, sdin16;
   logic mclk24, sck24, lrck24, sdin24;
   logic mute;
   assign if16.mute = mute;
   assign if24.mute = mute;

   speaker_i2s_ctrl #(.DATA_W(16)) dut16 (
      .clk(clk), .rst(rst), .bus(if16),
      .audio_mclk(mclk16), .audio_sck(sck16),
      .audio_lrck(lrck16), .audio_sdin(sdin16));

   speaker_i2s_ctrl #(.DATA_W(24)) dut24 (
      .clk(clk), .rst(rst), .bus(if24),
      .audio_mclk(mclk24), .audio_sck(sck24),
      .audio_lrck(lrck24), .audio_sdin(sdin24));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position and the words captured at each wrap.
   int          ph;
   logic [31:0] cL16, cR16, cL24, cR24;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph <= 0; cL16 <= 0; cR16 <= 0; cL24 <= 0; cR24 <= 0;
      end else begin
         if (ph == 2047) begin
            cL16 <= mute ? 0 : 32'(if16.audio_left);
            cR16 <= mute ? 0 : 32'(if16.audio_right);
            cL24 <= mute ? 0 : 32'(if24.audio_left);
            cR24 <= mute ? 0 : 32'(if24.audio_right);
         end
         ph <= (ph + 1) % 2048;
      end
   end

   // Expected {mclk, sck, lrck, sdin, sample_req} at frame position p.
   function automatic logic [31:0] exp_pins(input int p, input int dw,
                                            input logic [31:0] wl, input logic [31:0] wr);
      int slot;
      logic [31:0] w;
      logic sd;
      slot = (p % 1024) / 32;
      w    = (p >= 1024) ? wr : wl;
      sd   = (slot >= 1 && slot <= dw) ? w[dw - slot] : 1'b0;
      return {27'd0, 1'((p >> 1) & 1), 1'((p >> 4) & 1), 1'(p >> 10), sd, 1'(p == 2047)};
   endfunction

   always @(negedge clk) begin
      chk("pins16", {27'd0, mclk16, sck16, lrck16, sdin16, if16.sample_req},
          exp_pins(ph, 16, cL16, cR16));
      chk("pins24", {27'd0, mclk24, sck24, lrck24, sdin24, if24.sample_req},
          exp_pins(ph, 24, cL24, cR24));
   end

   task automatic wait_phase(input int p);
      int n = 0;
      while (ph != p && n < 4096) begin @(negedge clk); n++; end
      chk("wait_phase_timeout", 32'(n >= 4096), 32'd0);
   endtask

   // Runs to the next frame end, sampling sdin at each SCK rising edge.
   task automatic collect(input int clr, output logic [31:0] l16, output logic [31:0] r16,
                          output logic [31:0] l24, output logic [31:0] r24);
      int n = 0;
      int s;
      l16 = 0; r16 = 0; l24 = 0; r24 = 0;
      do begin
         @(negedge clk);
         n++;
         if (ph == clr) mute = 1'b0;
         if (ph % 32 == 16) begin
            s = (ph % 1024) / 32;
            if (ph < 1024) begin l16[31-s] = sdin16; l24[31-s] = sdin24; end
            else           begin r16[31-s] = sdin16; r24[31-s] = sdin24; end
         end
      end while (ph != 2047 && n < 2100);
      chk("collect_timeout", 32'(n >= 2100), 32'd0);
   endtask

   typedef struct {
      logic [15:0] l16, r16;
      logic [23:0] l24, r24;
      logic        m;
      int          clr;
      logic [15:0] eL16, eR16;
      logic [23:0] eL24, eR24;
   } vec_t;
   vec_t vecs[4];

   function automatic logic [31:0] fr16(input logic [15:0] w); return {1'b0, w, 15'd0}; endfunction
   function automatic logic [31:0] fr24(input logic [23:0] w); return {1'b0, w, 7'd0};  endfunction

   initial begin
      logic [31:0] a, b, c, d;
      int cyc;
      vecs[0] = '{16'hA5C3, 16'h0001, 24'h800001, 24'h5A5A5A, 1'b0, -1,
                  16'hA5C3, 16'h0001, 24'h800001, 24'h5A5A5A};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 500,
                  16'h0000, 16'h0000, 24'h000000, 24'h000000};
      vecs[2] = '{16'h8000, 16'h7FFF, 24'h7FFFFF, 24'h800000, 1'b0, -1,
                  16'h8000, 16'h7FFF, 24'h7FFFFF, 24'h800000};
      vecs[3] = '{16'h0001, 16'h8001, 24'h000001, 24'hFFFFFF, 1'b0, -1,
                  16'h0001, 16'h8001, 24'h000001, 24'hFFFFFF};

      if16.audio_left = 0; if16.audio_right = 0;
      if24.audio_left = 0; if24.audio_right = 0;
      mute = 1'b0;

      // Reset and free-run
      repeat (10) @(negedge clk);
      chk("reset_pins16", {mclk16, sck16, lrck16, sdin16, if16.sample_req}, 0);
      chk("reset_pins24", {mclk24, sck24, lrck24, sdin24, if24.sample_req}, 0);
      rst = 1'b0;
      cyc = 0;
      while (!if16.sample_req && cyc < 3000) begin @(negedge clk); cyc++; end
      chk("first_req_cycle", cyc, 2047);

      // Table vectors: apply at sample_req, check the following frame.
      for (int i = 0; i < 4; i++) begin
         wait_phase(2047);
         if16.audio_left = vecs[i].l16; if16.audio_right = vecs[i].r16;
         if24.audio_left = vecs[i].l24; if24.audio_right = vecs[i].r24;
         mute = vecs[i].m;
         collect(vecs[i].clr, a, b, c, d);
         chk($sformatf("vec%0d_L16", i), a, fr16(vecs[i].eL16));
         chk($sformatf("vec%0d_R16", i), b, fr16(vecs[i].eR16));
         chk($sformatf("vec%0d_L24", i), c, fr24(vecs[i].eL24));
         chk($sformatf("vec%0d_R24", i), d, fr24(vecs[i].eR24));
      end

      // Capture boundary: change inputs in the sample_req cycle and just after.
      wait_phase(2047);
      if16.audio_left = 16'h1234;
      collect(-1, a, b, c, d);
      chk("bnd_pre_L16", a, fr16(16'h1234));
      if16.audio_left = 16'h8000;
      @(negedge clk);
      if16.audio_left = 16'h7FFF;
      collect(-1, a, b, c, d);
      chk("bnd_cap_L16", a, fr16(16'h8000));
      collect(-1, a, b, c, d);
      chk("bnd_next_L16", a, fr16(16'h7FFF));

      // Random frames with ignored mid-frame input churn.
      for (int f = 0; f < 6; f++) begin
         int n;
         wait_phase(2047);
         if16.audio_left = 16'($urandom); if16.audio_right = 16'($urandom);
         if24.audio_left = 24'($urandom); if24.audio_right = 24'($urandom);
         mute = ($urandom_range(0, 3) == 0);
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (ph != 2047 && $urandom_range(0, 49) == 0) begin
               if16.audio_left = 16'($urandom); if16.audio_right = 16'($urandom);
               if24.audio_left = 24'($urandom); if24.audio_right = 24'($urandom);
               mute = $urandom_range(0, 1) == 1;
            end
         end while (ph != 2047 && n < 2100);
      end

      // Mid-frame reset during the right word of a nonzero frame.
      wait_phase(2047);
      if16.audio_left = 16'hA5C3; if16.audio_right = 16'hFFFF;
      if24.audio_left = 24'hFFFFFF; if24.audio_right = 24'hFFFFFF;
      mute = 1'b0;
      @(negedge clk);
      wait_phase(1100);
      chk("pre_rst_sdin16", 32'(sdin16), 32'(16'hFFFF >> 0 & 1));
      #2 rst = 1'b1;
      #1;
      chk("midrst_pins16", {mclk16, sck16, lrck16, sdin16, if16.sample_req}, 0);
      chk("midrst_pins24", {mclk24, sck24, lrck24, sdin24, if24.sample_req}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      while (!if16.sample_req && cyc < 3000) begin @(negedge clk); cyc++; end
      chk("rst_req_cycle", cyc, 2047);
      collect(-1, a, b, c, d);
      chk("post_rst_L16", a, fr16(16'hA5C3));
      chk("post_rst_R24", d, fr24(24'hFFFFFF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
